// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU test sequencer and its golden model.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } seq_state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam int unsigned N_VECTORS = 2048;
  localparam logic [7:0]  FAIL_SAT  = 8'd255;

endpackage

// File: rtl/alu_test_sequencer_if.sv
// Tiny-Tapeout style pin frame shared by the sequencer and the ALU tile it exercises.
interface alu_test_sequencer_if;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Sequencer side: drives operands/opcode, reads the ALU result.
  modport master (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

  // ALU / board side.
  modport slave (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference for the 4-bit ALU tile; opcode map must match the ALU exactly.
module alu_golden_model
  import alu_seq_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);

  logic [7:0] a8;
  logic [7:0] b8;

  always_comb begin
    a8 = {4'b0000, a};
    b8 = {4'b0000, b};
    y  = '0;
    case (opcode)
      OP_ADD:  y = a8 + b8;
      OP_SUB:  y = a8 - b8;
      OP_AND:  y = a8 & b8;
      OP_OR:   y = a8 | b8;
      OP_XOR:  y = a8 ^ b8;
      OP_NOT:  y = ~a8;
      OP_SHR:  y = a8 >> 1;
      OP_SHL:  y = a8 << 1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_test_sequencer.sv
// Sweeps all 2048 opcode/operand vectors through an external ALU and checks each result
// against alu_golden_model, reporting busy, done, sticky fail and a saturating fail count.
module alu_test_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  alu_test_sequencer_if.master tt
);

  seq_state_e state, state_n;
  logic [10:0] idx, idx_n;
  logic [2:0]  wait_cnt, wait_cnt_n;
  logic [7:0]  fail_cnt, fail_cnt_n;
  logic        fail, fail_n;

  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] stop_sync;
  logic start_s, stop_s, start_prev, start_evt;
  logic [7:0] golden_y;
  logic mismatch;
  logic unused_uio;

  assign unused_uio = ^tt.uio_in[5:0];
  assign tt.uio_oe  = 8'b0011_1111;

  // Synchronisers and the edge-detect history run regardless of ena, so an
  // edge that occurs while disabled is consumed and never seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_prev <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], tt.uio_in[6]};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], tt.uio_in[7]};
      start_prev <= start_s;
    end
  end

  assign start_s   = start_sync[SYNC_STAGES-1];
  assign stop_s    = stop_sync[SYNC_STAGES-1];
  assign start_evt = ena & start_s & ~start_prev;

  alu_golden_model u_golden (
    .opcode (idx[10:8]),
    .a      (idx[3:0]),
    .b      (idx[7:4]),
    .y      (golden_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      fail_cnt <= '0;
      fail     <= 1'b0;
    end else if (ena) begin
      state    <= state_n;
      idx      <= idx_n;
      wait_cnt <= wait_cnt_n;
      fail_cnt <= fail_cnt_n;
      fail     <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    wait_cnt_n = wait_cnt;
    fail_cnt_n = fail_cnt;
    fail_n     = fail;
    mismatch   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_evt) begin
          state_n    = DRIVE;
          idx_n      = '0;
          wait_cnt_n = '0;
          fail_cnt_n = '0;
          fail_n     = 1'b0;
        end
      end
      DRIVE: begin
        if (wait_cnt == 3'(LATENCY - 1)) begin
          state_n    = CHECK;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 3'd1;
        end
      end
      CHECK: begin
        mismatch = (tt.ui_in != golden_y);
        if (mismatch) begin
          fail_n = 1'b1;
          if (fail_cnt != FAIL_SAT) fail_cnt_n = fail_cnt + 8'd1;
        end
        if (mismatch && stop_s) begin
          state_n = DONE;
        end else if (idx == 11'(N_VECTORS - 1)) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 11'd1;
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tt.uo_out  = '0;
    tt.uio_out = '0;
    case (state)
      DRIVE, CHECK: begin
        tt.uo_out       = idx[7:0];
        tt.uio_out[2:0] = idx[10:8];
        tt.uio_out[3]   = 1'b1;
        tt.uio_out[5]   = fail;
      end
      DONE: begin
        tt.uo_out       = fail_cnt;
        tt.uio_out[2:0] = idx[10:8];
        tt.uio_out[4]   = 1'b1;
        tt.uio_out[5]   = fail;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Bench for alu_test_sequencer: a registered ALU model with optional faults is wired back
// to back; expected sweep outcomes are queued at start and checked when done rises.
module tb_alu_test_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SYNC = 2;

  typedef struct {
    int         cycles;
    logic [7:0] uo;
    logic [2:0] op;
    logic       fail;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  int   alu_mode = 0;
  int   busy_cycles = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_test_sequencer_if tt ();

  alu_test_sequencer #(.LATENCY(LAT), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tt    (tt)
  );

  always #5 clk = ~clk;

  // ALU under test: mode 1 breaks ADD by +1, mode 2 breaks NOT only at A=0,B=0.
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input int mode);
    logic [7:0] x, z, r;
    x = {4'h0, a};
    z = {4'h0, b};
    case (op)
      3'd0: r = x + z;
      3'd1: r = x - z;
      3'd2: r = x & z;
      3'd3: r = x | z;
      3'd4: r = x ^ z;
      3'd5: r = {4'hF, ~a};
      3'd6: r = {5'b0, a[3:1]};
      default: r = {3'b0, a, 1'b0};
    endcase
    if (mode == 1 && op == 3'd0) r = r + 8'd1;
    if (mode == 2 && op == 3'd5 && a == 4'h0 && b == 4'h0) r = r ^ 8'h01;
    return r;
  endfunction

  always @(posedge clk) tt.ui_in <= alu_ref(tt.uio_out[2:0], tt.uo_out[3:0], tt.uo_out[7:4], alu_mode);

  always @(negedge clk) if (tt.uio_out[3] === 1'b1) busy_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Raise start, confirm busy arrives in time with the first vector presented and fail clear.
  task automatic start_and_wait(input string tag);
    int lat;
    lat = 0;
    busy_cycles = 0;
    tt.uio_in[6] = 1'b1;
    for (int i = 1; i <= int'(SYNC) + 2; i++) begin
      tick();
      if (tt.uio_out[3] === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_busy_latency_ok"}, 32'((lat >= 1) && (lat <= int'(SYNC) + 2)), 32'd1);
    check({tag, "_first_uo"}, 32'(tt.uo_out), 32'h00);
    check({tag, "_first_op"}, 32'(tt.uio_out[2:0]), 32'd0);
    check({tag, "_first_fail"}, 32'(tt.uio_out[5]), 32'd0);
    tick();
    tick();
    tt.uio_in[6] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (tt.uio_out[4] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(e.cycles));
      check({tag, "_uo_out"}, 32'(tt.uo_out), 32'(e.uo));
      check({tag, "_opcode"}, 32'(tt.uio_out[2:0]), 32'(e.op));
      check({tag, "_fail"}, 32'(tt.uio_out[5]), 32'(e.fail));
      check({tag, "_busy_low"}, 32'(tt.uio_out[3]), 32'd0);
      check({tag, "_upper_zero"}, 32'(tt.uio_out[7:6]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] snap_uo, snap_uio;
    tt.uio_in = '0;
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_uo", 32'(tt.uo_out), 32'h00);
    check("reset_uio", 32'(tt.uio_out), 32'h00);
    check("reset_oe", 32'(tt.uio_oe), 32'h3F);
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_uo", 32'(tt.uo_out), 32'h00);
    check("idle_uio", 32'(tt.uio_out), 32'h00);

    // Clean sweep.
    alu_mode = 0;
    sb.push_back('{6144, 8'h00, 3'd7, 1'b0});
    start_and_wait("clean");
    wait_done("clean");

    // Broken ADD: 256 mismatches saturate the counter at 255.
    repeat (5) tick();
    alu_mode = 1;
    sb.push_back('{6144, 8'hFF, 3'd7, 1'b1});
    start_and_wait("addfault");
    wait_done("addfault");

    // Restart from DONE clears fail; ena freeze adds 50 cycles; a second start is ignored.
    repeat (5) tick();
    alu_mode = 0;
    sb.push_back('{6144 + 50, 8'h00, 3'd7, 1'b0});
    start_and_wait("freeze");
    repeat (100) tick();
    snap_uo = tt.uo_out;
    snap_uio = tt.uio_out;
    ena = 1'b0;
    repeat (50) tick();
    check("freeze_uo_held", 32'(tt.uo_out), 32'(snap_uo));
    check("freeze_uio_held", 32'(tt.uio_out), 32'(snap_uio));
    ena = 1'b1;
    repeat (200) tick();
    tt.uio_in[6] = 1'b1;
    repeat (5) tick();
    tt.uio_in[6] = 1'b0;
    wait_done("freeze");

    // Single NOT fault at idx 0x500 with stop_on_fail set.
    repeat (5) tick();
    alu_mode = 2;
    tt.uio_in[7] = 1'b1;
    repeat (4) tick();
    sb.push_back('{1281 * 3, 8'h01, 3'd5, 1'b1});
    start_and_wait("stop");
    wait_done("stop");
    tt.uio_in[7] = 1'b0;

    // Asynchronous reset mid-sweep, then a full sweep from idx 0.
    repeat (5) tick();
    alu_mode = 0;
    start_and_wait("abort");
    repeat (3000) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_uo", 32'(tt.uo_out), 32'h00);
    check("midreset_uio", 32'(tt.uio_out), 32'h00);
    check("midreset_oe", 32'(tt.uio_oe), 32'h3F);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("postreset_idle_uio", 32'(tt.uio_out), 32'h00);
    sb.push_back('{6144, 8'h00, 3'd7, 1'b0});
    start_and_wait("rerun");
    wait_done("rerun");
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_test_sequencer.md
Name: alu_test_sequencer

Overview:
Initiator-side companion to the team's 4-bit ALU tile. It drives packed operands on uo_out and opcodes on uio_out[2:0], reads the ALU result back on ui_in, and checks it against an internal golden model. It sweeps all 2048 vectors (8 opcodes × 256 operand pairs) and reports busy, done, sticky fail and a saturating fail count. It sits in the same Tiny-Tapeout-style port frame as the ALU, so the two tiles can be wired back to back on a board or in a bench.

Parameters:
LATENCY, 2, cycles a vector is held before the result is sampled (range 1..7)
SYNC_STAGES, 2, flops in the start/stop_on_fail input synchronisers (range 2..3)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
ena  in  1  tile enable; low freezes all state
ui_in  in  8  result Y returned by the ALU under test
uo_out  out  8  BUSY: {B,A} = idx[7:4],idx[3:0]; DONE: fail_cnt; IDLE: 0
uio_in  in  8  [6] start (async level), [7] stop_on_fail (async level), others ignored
uio_out  out  8  [2:0] opcode, [3] busy, [4] done, [5] fail (sticky), [7:6] 0
uio_oe  out  8  constant 8'b0011_1111

Behaviour:
- Reset: asynchronous, active-low. Takes effect immediately, mid-sweep included. State=IDLE, idx=0, wait_cnt=0, fail_cnt=0, fail=0, synchronisers cleared, uo_out=0, uio_out=0. uio_oe is constant and unaffected by reset.
- start and stop_on_fail each pass through a SYNC_STAGES-flop synchroniser. A start event is a 0->1 transition of the synchronised start.
- State IDLE: outputs all 0. A start event loads idx=0, fail_cnt=0, fail=0, wait_cnt=0 and moves to DRIVE on the next edge.
- State DRIVE: present the vector for idx:
  - uo_out = idx[7:0]
  - opcode = idx[10:8]
  - busy = 1
  - wait_cnt increments each cycle. When wait_cnt == LATENCY-1, go to CHECK and clear wait_cnt.
- State CHECK: vector outputs unchanged, busy = 1. Compare ui_in with golden(idx) this cycle.
  - Mismatch: fail <= 1; fail_cnt <= fail_cnt+1, saturating at 255.
  - Mismatch with synchronised stop_on_fail = 1: go to DONE; idx is retained.
  - Else if idx == 2047: go to DONE.
  - Else: idx <= idx+1 and return to DRIVE.
- Throughput: LATENCY+1 cycles per vector. A full sweep is 2048*(LATENCY+1) cycles, i.e. 6144 cycles at default.
- State DONE: uo_out = fail_cnt; uio_out[2:0] = idx[10:8] (opcode of the last vector checked); busy = 0; done = 1; fail held. A start event restarts exactly as from IDLE.
- Golden model. A = idx[3:0] and B = idx[7:4], both zero-extended to 8 bits; all arithmetic is 8-bit modulo 256:
  - 000: A+B
  - 001: A-B (two's-complement wrap, e.g. 0-1 = 8'hFF)
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: ~A over 8 bits (upper nibble 1111)
  - 110: A>>1
  - 111: A<<1
- Start events while busy are ignored.
- stop_on_fail is sampled only in CHECK and may change mid-sweep.
- ena = 0: all state, counters and outputs hold, and no edges are detected. Synchronisers keep running, so a start event arriving while ena = 0 is lost.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum {IDLE, DRIVE, CHECK, DONE}
  - opcode localparams (OP_ADD..OP_SHL = 0..7)
  - N_VECTORS = 2048
  - FAIL_SAT = 255
- One natural sub-module, alu_golden_model: combinational, (opcode[2:0], a[3:0], b[3:0]) -> y[7:0]. It stays bit-identical to the ALU opcode map so it can be reused by the ALU's own bench.

Test Plan:
- Correct ALU model wired back to back (result one edge after operands), LATENCY=2, start pulse -> busy within SYNC_STAGES+2 cycles; done after 6144 busy cycles; uo_out=0x00; fail=0.
- ALU model with ADD returning A+B+1, stop_on_fail=0 -> 256 mismatches; done; uo_out=0xFF (saturated); fail=1; uio_out[2:0]=3'b111.
- ALU model wrong only for opcode 101 at A=0,B=0, stop_on_fail=1 -> DONE at idx=0x500; uo_out=0x01; uio_out[2:0]=3'b101; fail=1.
- rst_n low for 1 cycle at idx≈1000 -> all outputs 0 immediately; IDLE; a later start runs the full sweep from idx 0.
- ena low for 50 cycles mid-DRIVE -> uo_out/uio_out frozen; completion time extended by exactly 50 cycles; fail_cnt unchanged.
- Second start pulse while busy -> ignored (idx not reset). Start pulse in DONE -> new sweep with fail_cnt and fail cleared.
